// File: rtl/common.sv
// Shared core-wide types: register-file address.
package common;
   localparam int unsigned REG_AW = 5;
   typedef logic [REG_AW-1:0] creg_addr_t;
endpackage

// File: rtl/pipes.sv
// Pipeline command and stage-control types shared by the hazard unit and pipe_ctrl.
package pipes;
   import common::*;

   typedef struct packed {
      logic [1:0] forwardA;
      logic [1:0] forwardB;
      logic       stallF;
      logic       stallD;
      logic       stallE;
      logic       flushM;
   } hazard_data_t;

   typedef struct packed {
      logic       valid;
      creg_addr_t rs;
      creg_addr_t rt;
      creg_addr_t dst;
      logic       reg_write;
      logic       mem_to_reg;
   } stage_ctl_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select over register-file, W and M sources; flags the unused code.
module fwd_mux
   import pipes::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic [1:0]    sel,
   input  logic [DW-1:0] rf,
   input  logic [DW-1:0] w,
   input  logic [DW-1:0] m,
   output logic [DW-1:0] y_c,
   output logic          illegal_c
);

   always_comb begin
      y_c       = rf;
      illegal_c = 1'b0;
      case (sel)
         FWD_M:   y_c = m;
         FWD_W:   y_c = w;
         FWD_RF:  y_c = rf;
         default: illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// D/E/M/W stage-control registers with stall/flush/forward handling and perf counters.
module pipe_ctrl
   import common::*;
   import pipes::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  hazard_data_t  hazard_data,
   input  logic          fetch_valid,
   input  creg_addr_t    dec_rs,
   input  creg_addr_t    dec_rt,
   input  creg_addr_t    dec_dst,
   input  logic          dec_reg_write,
   input  logic          dec_mem_to_reg,
   input  logic [DW-1:0] rd1_D,
   input  logic [DW-1:0] rd2_D,
   input  logic [DW-1:0] alu_result_M,
   input  logic [DW-1:0] result_W,
   output logic          pc_en,
   output creg_addr_t    rsE,
   output creg_addr_t    rtE,
   output creg_addr_t    write_reg_M,
   output creg_addr_t    write_reg_W,
   output logic          mem_to_reg_E,
   output logic          mem_to_reg_M,
   output logic          mem_to_reg_W,
   output logic          reg_write_M,
   output logic          reg_write_W,
   output logic          valid_D,
   output logic          valid_E,
   output logic          valid_M,
   output logic          valid_W,
   output logic [DW-1:0] srcA_E,
   output logic [DW-1:0] srcB_E,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] bubble_cnt,
   output logic [CW-1:0] retire_cnt,
   output logic          proto_err
);

   stage_ctl_t    d_q, e_q, m_q, w_q;
   stage_ctl_t    dec_c;
   logic [DW-1:0] rd1_q, rd2_q;
   logic          err_a_c, err_b_c;
   logic          m_bubble_c;
   logic          unused_fields;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + CW'(1);
   endfunction

   assign dec_c = '{valid:      fetch_valid,
                    rs:         dec_rs,
                    rt:         dec_rt,
                    dst:        dec_dst,
                    reg_write:  dec_reg_write,
                    mem_to_reg: dec_mem_to_reg};

   assign m_bubble_c = hazard_data.flushM | hazard_data.stallE;

   // rd1_D/rd2_D are the register-file reads for the instruction currently held in D.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_q        <= '0;
         e_q        <= '0;
         m_q        <= '0;
         w_q        <= '0;
         rd1_q      <= '0;
         rd2_q      <= '0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         retire_cnt <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (!hazard_data.stallD) d_q <= dec_c;

         if (!hazard_data.stallE) begin
            if (hazard_data.stallD) begin
               e_q   <= '0;
               rd1_q <= '0;
               rd2_q <= '0;
            end else begin
               e_q   <= d_q;
               rd1_q <= rd1_D;
               rd2_q <= rd2_D;
            end
         end

         m_q <= m_bubble_c ? '0 : e_q;
         w_q <= m_q;

         if (hazard_data.stallF | hazard_data.stallD | hazard_data.stallE)
            stall_cnt <= sat_inc(stall_cnt);
         if (m_bubble_c) bubble_cnt <= sat_inc(bubble_cnt);
         if (w_q.valid)  retire_cnt <= sat_inc(retire_cnt);

         if ((hazard_data.stallE & ~hazard_data.stallD) | err_a_c | err_b_c)
            proto_err <= 1'b1;
      end
   end

   fwd_mux #(.DW(DW)) u_fwd_a (
      .sel       (hazard_data.forwardA),
      .rf        (rd1_q),
      .w         (result_W),
      .m         (alu_result_M),
      .y_c       (srcA_E),
      .illegal_c (err_a_c)
   );

   fwd_mux #(.DW(DW)) u_fwd_b (
      .sel       (hazard_data.forwardB),
      .rf        (rd2_q),
      .w         (result_W),
      .m         (alu_result_M),
      .y_c       (srcB_E),
      .illegal_c (err_b_c)
   );

   // Reset forces the PC enable so fetch restarts on the first edge after release.
   assign pc_en        = reset | ~hazard_data.stallF;

   assign valid_D      = d_q.valid;
   assign valid_E      = e_q.valid;
   assign valid_M      = m_q.valid;
   assign valid_W      = w_q.valid;
   assign rsE          = e_q.rs;
   assign rtE          = e_q.rt;
   assign write_reg_M  = m_q.dst;
   assign write_reg_W  = w_q.dst;
   assign mem_to_reg_E = e_q.mem_to_reg & e_q.valid;
   assign mem_to_reg_M = m_q.mem_to_reg & m_q.valid;
   assign mem_to_reg_W = w_q.mem_to_reg & w_q.valid;
   assign reg_write_M  = m_q.reg_write  & m_q.valid;
   assign reg_write_W  = w_q.reg_write  & w_q.valid;

   assign unused_fields = ^{d_q.rs, d_q.rt, d_q.dst, d_q.reg_write, d_q.mem_to_reg,
                            e_q.dst, e_q.reg_write, m_q.rs, m_q.rt, w_q.rs, w_q.rt};

endmodule
